sdp_relu_layer_ctrl: RTL and testbench
======================================

# sdp_relu_layer_ctrl

Per-layer sequencer for the SDP ReLU stage. It latches the layer configuration at start and admits input beats into the fixed-latency ReLU datapath. Admission is credit-gated against the downstream buffer. After the last beat retires from the pipe, it raises the config-triosy handshake and layer-done. It sits between the SDP input channel and the ReLU core, and replaces free-running oswt gating with explicit layer accounting.

## Interface
- PIPE_LAT, 2: ReLU datapath latency in cycles, issue to output valid; legal range 1..7.
- CREDITS, 4: downstream buffer entries; legal range 1..15.
- CNT_W, 13: beat-count width.
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  asynchronous active-low reset.
- op_en  in  1  layer start pulse; sampled only in IDLE.
- cfg_beat_cnt  in  CNT_W  beats in layer minus one.
- cfg_relu_bypass  in  1  bypass ReLU for this layer.
- cfg_precision  in  2  element precision: 0=int8, 1=int16, 2=fp16, 3 reserved.
- up_vld  in  1  input beat valid.
- up_rdy  out  1  input beat accepted when up_vld&up_rdy.
- dp_issue  out  1  launch one beat into ReLU datapath.
- dp_last  out  1  qualifies dp_issue: final beat of layer.
- dp_bypass  out  1  latched cfg_relu_bypass.
- dp_precision  out  2  latched cfg_precision.
- dn_credit_ret  in  1  downstream freed one entry.
- cfg_relu_bypass_triosy_lz  out  1  one-cycle config-consumed pulse.
- layer_done  out  1  one-cycle layer-complete pulse.
- busy  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: on op_en, latch cfg_* into shadow registers, clear beat counter, go to RUN.
  - RUN: up_rdy = (credit>0). An accepted beat asserts dp_issue the same cycle, decrements credit and increments the beat counter. The beat where counter==cfg_beat_cnt asserts dp_last and moves to DRAIN.
  - DRAIN: up_rdy=0. Wait PIPE_LAT cycles after the last issue, tracked by a lat down-counter, then go to DONE.
  - DONE: one cycle only. Pulse layer_done and cfg_relu_bypass_triosy_lz, then return to IDLE.
- Credit counter:
  - Width clog2(CREDITS+1).
  - Issue without return: decrement. Return without issue: increment. Both in the same cycle: unchanged.
  - A return while credit==CREDITS is a protocol error. Saturate at CREDITS and set sticky err bit, readable via the sub-module port only.
- Credits persist across layers and are never reset by op_en.
- op_en outside IDLE is ignored, with no queueing.
- cfg_* changes after latch do not affect the running layer.
- cfg_precision==3 is latched as-is; the ReLU core treats it as int8.
- cfg_beat_cnt=0 means a one-beat layer: the first accepted beat carries dp_last.

## Timing
- Reset (async assert, sync deassert externally):
  - state=IDLE, credit=CREDITS, counters 0.
  - All outputs 0, including dp_bypass and dp_precision.
- op_en at cycle t gives busy=1 and up_rdy possible at t+1.
- up_rdy and dp_issue are combinational from state and credit; no registered skid.
- Last beat issued at cycle L: layer_done and triosy pulse at L+PIPE_LAT+1, and busy=0 at L+PIPE_LAT+2.
- A new op_en is accepted at L+PIPE_LAT+2 at the earliest, which gives back-to-back layers with no bubble beyond that.
- Reset mid-layer aborts immediately with no done pulse. Credit returns to CREDITS, and the downstream buffer must be reset by the same rstn.

## Structure
- A shared sdp_relu_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - the precision codes;
  - PIPE_LAT_MAX=7 and CREDITS_MAX=15.
- One sub-module, sdp_relu_credit_cnt, holds the up/down saturating counter with its err flag, reusable by other SDP stages.
- The FSM, beat counter and latency counter live in the top.

## Test plan
- Single-beat layer:
  - Stimulus: cfg_beat_cnt=0, up_vld held high, credits free.
  - Response: dp_issue and dp_last on the same cycle, and layer_done exactly PIPE_LAT+1 cycles later.
- Credit stall:
  - Stimulus: CREDITS=4, cfg_beat_cnt=9, no dn_credit_ret.
  - Response: exactly 4 issues, up_rdy=0 thereafter. Each single return releases exactly one beat.
- Simultaneous issue and return:
  - Stimulus: credit=1 with issue and dn_credit_ret in the same cycle.
  - Response: credit stays 1 and streaming continues without a bubble.
- Config latch:
  - Stimulus: start with bypass=1, precision=2, then toggle the cfg inputs mid-layer.
  - Response: dp_bypass=1 and dp_precision=2 hold until the next op_en.
- Back-to-back layers:
  - Stimulus: op_en during DRAIN, then op_en the cycle after layer_done.
  - Response: the first op_en is ignored; the second starts a layer, and cfg_relu_bypass_triosy_lz pulses once per layer.
- Reset abort:
  - Stimulus: rstn low while 3 of 8 beats are issued.
  - Response: all outputs 0, credit=CREDITS, no layer_done pulse.

Source files
------------

// File: rtl/sdp_relu_pkg.sv
// Shared types and limits for the SDP ReLU stage: FSM states, precision codes, parameter ceilings.
package sdp_relu_pkg;

  localparam int PIPE_LAT_MAX = 7;
  localparam int CREDITS_MAX  = 15;
  localparam int LAT_W        = $clog2(PIPE_LAT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Code 3 is reserved; the ReLU core treats it as int8, so it is carried through unchanged.
  typedef enum logic [1:0] {
    PREC_INT8  = 2'd0,
    PREC_INT16 = 2'd1,
    PREC_FP16  = 2'd2,
    PREC_RSVD  = 2'd3
  } prec_e;

endpackage

// File: rtl/sdp_relu_credit_cnt.sv
// Up/down credit counter, resets full, saturates at MAX on an over-return and flags it stickily.
// Single-cycle update; the caller must only decrement while the count is non-zero.
module sdp_relu_credit_cnt
  import sdp_relu_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(MAX);
      err <= 1'b0;
    end else if (inc && !dec) begin
      if (cnt == W'(MAX)) begin
        err <= 1'b1;
      end else begin
        cnt <= cnt + W'(1);
      end
    end else if (dec && !inc) begin
      if (cnt != '0) begin
        cnt <= cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/sdp_relu_layer_ctrl.sv
// Per-layer sequencer: latches config at start, admits credit-gated beats into the ReLU pipe,
// then waits out the pipe latency and pulses layer_done / config-triosy once per layer.
module sdp_relu_layer_ctrl
  import sdp_relu_pkg::*;
#(
  parameter int PIPE_LAT = 2,
  parameter int CREDITS  = 4,
  parameter int CNT_W    = 13
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             op_en,
  input  logic [CNT_W-1:0] cfg_beat_cnt,
  input  logic             cfg_relu_bypass,
  input  logic [1:0]       cfg_precision,
  input  logic             up_vld,
  output logic             up_rdy,
  output logic             dp_issue,
  output logic             dp_last,
  output logic             dp_bypass,
  output logic [1:0]       dp_precision,
  input  logic             dn_credit_ret,
  output logic             cfg_relu_bypass_triosy_lz,
  output logic             layer_done,
  output logic             busy
);

  localparam int CRD_W = $clog2(CREDITS + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] beat_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [LAT_W-1:0] lat_q;
  logic             bypass_q;
  prec_e            prec_q;
  logic [CRD_W-1:0] credit;
  logic             unused_credit_err;
  logic             last_beat;

  sdp_relu_credit_cnt #(
    .MAX (CREDITS),
    .W   (CRD_W)
  ) u_credit (
    .clk   (nvdla_core_clk),
    .rst_n (nvdla_core_rstn),
    .inc   (dn_credit_ret),
    .dec   (dp_issue),
    .cnt   (credit),
    .err   (unused_credit_err)
  );

  assign dp_issue     = up_rdy & up_vld;
  assign last_beat    = (beat_q == beat_cnt_q);
  assign dp_last      = dp_issue & last_beat;
  assign dp_bypass    = bypass_q;
  assign dp_precision = prec_q;

  always_comb begin
    state_d                   = state_q;
    up_rdy                    = 1'b0;
    busy                      = 1'b1;
    layer_done                = 1'b0;
    cfg_relu_bypass_triosy_lz = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (op_en) state_d = ST_RUN;
      end
      ST_RUN: begin
        up_rdy = (credit != '0);
        if (up_rdy && up_vld && last_beat) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (lat_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        layer_done                = 1'b1;
        cfg_relu_bypass_triosy_lz = 1'b1;
        state_d                   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow config only moves on an accepted start, so mid-layer cfg changes are invisible.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_cnt_q <= '0;
      bypass_q   <= 1'b0;
      prec_q     <= PREC_INT8;
    end else if (state_q == ST_IDLE && op_en) begin
      beat_cnt_q <= cfg_beat_cnt;
      bypass_q   <= cfg_relu_bypass;
      prec_q     <= prec_e'(cfg_precision);
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      beat_q <= '0;
    end else if (state_q == ST_IDLE && op_en) begin
      beat_q <= '0;
    end else if (dp_issue) begin
      beat_q <= beat_q + CNT_W'(1);
    end
  end

  // Loaded with PIPE_LAT-1 so DRAIN spans PIPE_LAT cycles and DONE lands at last+PIPE_LAT+1.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      lat_q <= '0;
    end else if (dp_last) begin
      lat_q <= LAT_W'(PIPE_LAT - 1);
    end else if (state_q == ST_DRAIN && lat_q != '0) begin
      lat_q <= lat_q - LAT_W'(1);
    end
  end

endmodule

// File: tb/tb_sdp_relu_layer_ctrl.sv
// Directed bench for sdp_relu_layer_ctrl: single beat, credit stall, issue+return, config latch,
// back-to-back layers, over-return saturation and mid-layer reset abort.
module tb_sdp_relu_layer_ctrl;

  localparam int PIPE_LAT = 2;
  localparam int CREDITS  = 4;
  localparam int CNT_W    = 13;

  logic             clk;
  logic             rstn;
  logic             op_en;
  logic [CNT_W-1:0] cfg_beat_cnt;
  logic             cfg_relu_bypass;
  logic [1:0]       cfg_precision;
  logic             up_vld;
  logic             up_rdy;
  logic             dp_issue;
  logic             dp_last;
  logic             dp_bypass;
  logic [1:0]       dp_precision;
  logic             dn_credit_ret;
  logic             triosy;
  logic             layer_done;
  logic             busy;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int triosy_cnt = 0;

  sdp_relu_layer_ctrl #(
    .PIPE_LAT (PIPE_LAT),
    .CREDITS  (CREDITS),
    .CNT_W    (CNT_W)
  ) dut (
    .nvdla_core_clk            (clk),
    .nvdla_core_rstn           (rstn),
    .op_en                     (op_en),
    .cfg_beat_cnt              (cfg_beat_cnt),
    .cfg_relu_bypass           (cfg_relu_bypass),
    .cfg_precision             (cfg_precision),
    .up_vld                    (up_vld),
    .up_rdy                    (up_rdy),
    .dp_issue                  (dp_issue),
    .dp_last                   (dp_last),
    .dp_bypass                 (dp_bypass),
    .dp_precision              (dp_precision),
    .dn_credit_ret             (dn_credit_ret),
    .cfg_relu_bypass_triosy_lz (triosy),
    .layer_done                (layer_done),
    .busy                      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (layer_done) done_cnt++;
    if (triosy) triosy_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_up_rdy"}, int'(up_rdy), 0);
    chk({tag, "_dp_issue"}, int'(dp_issue), 0);
    chk({tag, "_dp_last"}, int'(dp_last), 0);
    chk({tag, "_dp_bypass"}, int'(dp_bypass), 0);
    chk({tag, "_dp_precision"}, int'(dp_precision), 0);
    chk({tag, "_triosy"}, int'(triosy), 0);
    chk({tag, "_layer_done"}, int'(layer_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_credit"}, int'(dut.u_credit.cnt), CREDITS);
    chk({tag, "_err"}, int'(dut.u_credit.err), 0);
  endtask

  initial begin
    int issued;
    int n;

    rstn            = 1'b0;
    op_en           = 1'b0;
    cfg_beat_cnt    = '0;
    cfg_relu_bypass = 1'b0;
    cfg_precision   = 2'd0;
    up_vld          = 1'b0;
    dn_credit_ret   = 1'b0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single-beat layer
    op_en = 1'b1; cfg_beat_cnt = 13'd0; cfg_relu_bypass = 1'b0; cfg_precision = 2'd0;
    tick();
    op_en = 1'b0;
    chk("single_busy", int'(busy), 1);
    up_vld = 1'b1;
    #1;
    chk("single_issue", int'(dp_issue), 1);
    chk("single_last", int'(dp_last), 1);
    n = 0;
    do begin
      tick();
      up_vld = 1'b0;
      n++;
    end while (!layer_done && n < 16);
    chk("single_done_lat", n, PIPE_LAT + 1);
    chk("single_triosy", int'(triosy), 1);
    tick();
    chk("single_busy_end", int'(busy), 0);
    chk("single_credit", int'(dut.u_credit.cnt), CREDITS - 1);
    dn_credit_ret = 1'b1;
    tick();
    dn_credit_ret = 1'b0;
    chk("single_credit_ret", int'(dut.u_credit.cnt), CREDITS);

    // Credit stall with config latch: 10 beats, bypass=1, precision=fp16
    op_en = 1'b1; cfg_beat_cnt = 13'd9; cfg_relu_bypass = 1'b1; cfg_precision = 2'd2;
    tick();
    op_en = 1'b0;
    cfg_beat_cnt = 13'd3; cfg_relu_bypass = 1'b0; cfg_precision = 2'd1;
    up_vld = 1'b1;
    #1;
    issued = 0;
    for (int i = 0; i < 6; i++) begin
      if (dp_issue) issued++;
      tick();
    end
    chk("stall_issues", issued, CREDITS);
    chk("stall_up_rdy", int'(up_rdy), 0);
    chk("latch_bypass_mid", int'(dp_bypass), 1);
    chk("latch_prec_mid", int'(dp_precision), 2);

    dn_credit_ret = 1'b1;
    tick();
    dn_credit_ret = 1'b0;
    #1;
    chk("ret1_issue", int'(dp_issue), 1);
    chk("ret1_last", int'(dp_last), 0);
    tick();
    chk("ret1_stall_again", int'(up_rdy), 0);

    // Simultaneous issue and return keep credit at 1 with no bubble
    dn_credit_ret = 1'b1;
    tick();
    for (int b = 5; b <= 9; b++) begin
      chk("simul_issue", int'(dp_issue), 1);
      chk("simul_last", int'(dp_last), (b == 9) ? 1 : 0);
      tick();
      chk("simul_credit", int'(dut.u_credit.cnt), 1);
    end
    dn_credit_ret = 1'b0;
    up_vld = 1'b0;

    // op_en during DRAIN is ignored
    op_en = 1'b1;
    #1;
    chk("drain_busy", int'(busy), 1);
    chk("drain_up_rdy", int'(up_rdy), 0);
    tick();
    op_en = 1'b0;
    chk("drain_no_done", int'(layer_done), 0);
    tick();
    chk("stall_done", int'(layer_done), 1);
    chk("stall_triosy", int'(triosy), 1);
    chk("latch_bypass_end", int'(dp_bypass), 1);
    chk("latch_prec_end", int'(dp_precision), 2);
    tick();
    chk("b2b_idle", int'(busy), 0);

    // Back-to-back: start the cycle after layer_done, 2 beats, reserved precision
    op_en = 1'b1; cfg_beat_cnt = 13'd1; cfg_relu_bypass = 1'b0; cfg_precision = 2'd3;
    tick();
    op_en = 1'b0;
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_bypass", int'(dp_bypass), 0);
    chk("b2b_prec", int'(dp_precision), 3);
    up_vld = 1'b1;
    dn_credit_ret = 1'b1;
    #1;
    chk("b2b_beat0_issue", int'(dp_issue), 1);
    chk("b2b_beat0_last", int'(dp_last), 0);
    tick();
    dn_credit_ret = 1'b0;
    chk("b2b_beat1_issue", int'(dp_issue), 1);
    chk("b2b_beat1_last", int'(dp_last), 1);
    n = 0;
    do begin
      tick();
      up_vld = 1'b0;
      n++;
    end while (!layer_done && n < 16);
    chk("b2b_done_lat", n, PIPE_LAT + 1);
    tick();
    chk("b2b_credit", int'(dut.u_credit.cnt), 0);

    // Refill, then one over-return saturates and sets the sticky error
    dn_credit_ret = 1'b1;
    repeat (CREDITS) tick();
    chk("refill_credit", int'(dut.u_credit.cnt), CREDITS);
    chk("refill_err", int'(dut.u_credit.err), 0);
    tick();
    dn_credit_ret = 1'b0;
    chk("over_credit", int'(dut.u_credit.cnt), CREDITS);
    chk("over_err", int'(dut.u_credit.err), 1);

    // Reset abort after 3 of 8 beats
    op_en = 1'b1; cfg_beat_cnt = 13'd7; cfg_relu_bypass = 1'b1; cfg_precision = 2'd1;
    tick();
    op_en = 1'b0;
    up_vld = 1'b1;
    #1;
    issued = 0;
    for (int i = 0; i < 3; i++) begin
      if (dp_issue) issued++;
      tick();
    end
    chk("abort_issued", issued, 3);
    chk("abort_credit_pre", int'(dut.u_credit.cnt), CREDITS - 3);
    rstn = 1'b0;
    #1;
    up_vld = 1'b0;
    chk_idle_outputs("abort");
    repeat (3) tick();
    @(negedge clk);
    rstn = 1'b1;
    repeat (PIPE_LAT + 3) tick();
    chk("abort_busy_after", int'(busy), 0);
    chk("layer_done_total", done_cnt, 3);
    chk("triosy_total", triosy_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
